// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - instruction-format kind encoding shared by decoder stages and benches
package decoder_pkg;

  typedef enum logic [2:0] {
    KIND_RRR     = 3'd0,
    KIND_MEMORY  = 3'd1,
    KIND_MODEL   = 3'd2,
    KIND_RRI     = 3'd3,
    KIND_CUSTOM  = 3'd4,
    KIND_INVALID = 3'd7
  } e_kind;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;

endpackage

// File: rtl/decoder_kind.sv
// rtl/decoder_kind.sv - first-stage classifier: opcode nibble to format kind, plus a registered copy
module decoder_kind
  import decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        instr_valid,
  output e_kind       kind,
  output e_kind       kind_q,
  output logic        kind_valid_q,
  output logic        illegal_q
);

  logic [3:0] opcode;
  logic       illegal_d;
  logic       unused_low_bits;

  assign opcode          = instruction[OPC_MSB:OPC_LSB];
  assign unused_low_bits = ^instruction[OPC_LSB-1:0];

  // All 16 codes are listed; the default arm is reached only by X/Z and keeps them visible.
  always_comb begin
    kind = KIND_INVALID;
    case (opcode)
      4'h0:                   kind = KIND_RRR;
      4'h1:                   kind = KIND_MEMORY;
      4'h2:                   kind = KIND_MODEL;
      4'h3:                   kind = KIND_INVALID;
      4'h4, 4'h5, 4'h6, 4'h7: kind = KIND_RRI;
      4'h8, 4'h9, 4'hA, 4'hB: kind = KIND_INVALID;
      4'hC, 4'hD, 4'hE, 4'hF: kind = KIND_CUSTOM;
      default:                kind = e_kind'(3'bxxx);
    endcase
  end

  assign illegal_d = instr_valid && (kind == KIND_INVALID);

  // kind_q follows every cycle; consumers qualify it with kind_valid_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q       <= KIND_INVALID;
      kind_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      kind_q       <= kind;
      kind_valid_q <= instr_valid;
      illegal_q    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_decoder_kind.sv
// tb/tb_decoder_kind.sv - randomized self-checking bench for decoder_kind against a table model
module tb_decoder_kind;
  import decoder_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        instr_valid;
  e_kind       kind;
  e_kind       kind_q;
  logic        kind_valid_q;
  logic        illegal_q;

  int vectors;
  int miscompares;

  decoder_kind dut (
    .clk          (clk),
    .rst          (rst),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .kind         (kind),
    .kind_q       (kind_q),
    .kind_valid_q (kind_valid_q),
    .illegal_q    (illegal_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the format table as numeric ranges.
  function automatic logic [2:0] ref_kind(input logic [31:0] word);
    int nib;
    nib = int'(word >> 28);
    if (nib == 0)                 return 3'd0;
    else if (nib == 1)            return 3'd1;
    else if (nib == 2)            return 3'd2;
    else if (nib >= 4 && nib < 8) return 3'd3;
    else if (nib >= 12)           return 3'd4;
    else                          return 3'd7;
  endfunction

  // Called just after a falling edge: drive, check comb path, then check the registered path.
  task automatic step(input logic [31:0] word, input logic valid, input logic reset, input string tag);
    logic [2:0] exp_k;
    exp_k       = ref_kind(word);
    instruction = word;
    instr_valid = valid;
    rst         = reset;
    #1;
    check_val({tag, ".kind"}, 32'(kind), 32'(exp_k));
    @(negedge clk);
    if (reset) begin
      check_val({tag, ".kind_q"},  32'(kind_q), 32'd7);
      check_val({tag, ".valid_q"}, 32'(kind_valid_q), 32'd0);
      check_val({tag, ".illegal"}, 32'(illegal_q), 32'd0);
    end else begin
      check_val({tag, ".kind_q"},  32'(kind_q), 32'(exp_k));
      check_val({tag, ".valid_q"}, 32'(kind_valid_q), 32'(valid));
      check_val({tag, ".illegal"}, 32'(illegal_q), 32'(valid && exp_k == 3'd7));
    end
  endtask

  logic [31:0] directed [16];
  logic [2:0]  directed_exp [16];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    instruction = 32'h0;
    instr_valid = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset.kind_q",  32'(kind_q), 32'd7);
    check_val("reset.valid_q", 32'(kind_valid_q), 32'd0);
    check_val("reset.illegal", 32'(illegal_q), 32'd0);

    directed = '{32'h00000000, 32'h0fffffff, 32'h10000000, 32'h1fffffff,
                 32'h20000000, 32'h2fffffff, 32'h30000000, 32'h3fffffff,
                 32'h80000000, 32'hbfffffff, 32'h40000000, 32'h7fffffff,
                 32'hc0000000, 32'hffffffff, 32'h90000000, 32'ha5a5a5a5};
    directed_exp = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd7, 3'd7,
                     3'd7, 3'd7, 3'd3, 3'd3, 3'd4, 3'd4, 3'd7, 3'd7};
    for (int i = 0; i < 16; i++) begin
      instruction = directed[i];
      #10;
      check_val($sformatf("table[%08h]", directed[i]), 32'(kind), 32'(directed_exp[i]));
    end

    @(negedge clk);
    step(32'h4000_0000, 1'b1, 1'b0, "pipe_rri");
    step(32'h9000_0000, 1'b1, 1'b0, "illegal_v1");
    step(32'h9000_0000, 1'b0, 1'b0, "illegal_v0");
    step(32'hc000_0000, 1'b1, 1'b1, "rst_priority");
    step(32'h1234_5678, 1'b1, 1'b0, "post_rst");

    for (int n = 0; n < 320; n++) begin
      logic [31:0] w;
      w = {4'(n % 16), 28'($urandom)};
      step(w, 1'($urandom), ($urandom_range(0, 15) == 0), $sformatf("sweep%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
